// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, 16x oversampling with a 3-sample
// majority vote per bit. Received bytes are held under a valid/ack handshake.
// Framing errors produce a one-clock pulse, and an overwritten unacknowledged
// byte sets a sticky overrun flag.
module uart_rx #(
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sampleTick,
   input  logic       rx,
   input  logic       ack,
   output logic [7:0] data,
   output logic       valid,
   output logic       frameErr,
   output logic       overrun,
   output logic       busy
);

   localparam logic [3:0] CNT_LAST = 4'(OVERSAMPLE - 1);
   localparam logic [3:0] CNT_VOTE = 4'(OVERSAMPLE / 2 + 1);
   localparam logic [3:0] CNT_S0   = CNT_VOTE - 4'd2;
   localparam logic [3:0] CNT_S1   = CNT_VOTE - 4'd1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t     state, state_next;
   logic [3:0] cnt, cnt_next;
   logic [2:0] bit_idx, bit_next;
   logic [7:0] shift, shift_next;
   logic       rx_meta, rx_s, rx_prev;
   logic       samp0, samp1, maj;
   logic       load, ferr;

   // Two-flop synchronizer for the asynchronous serial line
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // State register, counters, shift register and vote samples (tick-gated)
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
         rx_prev <= 1'b1;
         samp0   <= 1'b1;
         samp1   <= 1'b1;
      end else if (sampleTick) begin
         state   <= state_next;
         cnt     <= cnt_next;
         bit_idx <= bit_next;
         shift   <= shift_next;
         rx_prev <= rx_s;
         if (cnt == CNT_S0) samp0 <= rx_s;
         if (cnt == CNT_S1) samp1 <= rx_s;
      end
   end

   // Majority of the samples taken at cnt 7, 8 and the live one at cnt 9
   assign maj = (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);

   // Next-state logic; load/ferr are single-cycle strobes at the STOP vote
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      bit_next   = bit_idx;
      shift_next = shift;
      load       = 1'b0;
      ferr       = 1'b0;
      if (sampleTick) begin
         case (state)
            IDLE: begin
               if (rx_prev && !rx_s) begin
                  state_next = START;
                  cnt_next   = '0;
               end
            end
            START: begin
               cnt_next = cnt + 4'd1;
               if (cnt == CNT_VOTE && maj) begin
                  state_next = IDLE;
                  cnt_next   = '0;
               end else if (cnt == CNT_LAST) begin
                  state_next = DATA;
                  cnt_next   = '0;
                  bit_next   = '0;
               end
            end
            DATA: begin
               cnt_next = cnt + 4'd1;
               if (cnt == CNT_VOTE) shift_next = {maj, shift[7:1]};
               if (cnt == CNT_LAST) begin
                  cnt_next = '0;
                  if (bit_idx == 3'd7) state_next = STOP;
                  else                 bit_next   = bit_idx + 3'd1;
               end
            end
            STOP: begin
               cnt_next = cnt + 4'd1;
               if (cnt == CNT_VOTE) begin
                  state_next = IDLE;
                  cnt_next   = '0;
                  if (maj) load = 1'b1;
                  else     ferr = 1'b1;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Output decode from the state register
   always_comb begin
      busy = (state != IDLE);
   end

   // Consumer handshake: a new byte wins over ack; ack in the same cycle
   // only suppresses the overrun flag
   always_ff @(posedge clk) begin
      if (rst) begin
         data     <= '0;
         valid    <= 1'b0;
         overrun  <= 1'b0;
         frameErr <= 1'b0;
      end else begin
         frameErr <= ferr;
         if (load) begin
            data    <= shift;
            valid   <= 1'b1;
            overrun <= valid && !ack;
         end else if (ack && valid) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven plus randomized check of uart_rx against an
// event-level model of the received byte, handshake and error flags.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sampleTick = 1'b1;
   logic       rx = 1'b1;
   logic       ack = 1'b0;
   logic [7:0] data;
   logic       valid, frameErr, overrun, busy;

   int unsigned applied = 0;
   int unsigned miscompares = 0;
   int unsigned tick_div = 1;
   int unsigned tick_ph = 0;
   int          fe_cycles = 0;
   int          fe_pulses = 0;
   logic        fe_last = 1'b0;
   logic        busy_seen = 1'b0;

   // behavioural model
   int m_data = 0;
   int m_valid = 0;
   int m_ov = 0;
   int m_fe = 0;

   typedef struct {
      bit         is_ack;
      logic [7:0] b;
      logic       stop;
      int         exp_data;
      int         exp_valid;
      int         exp_ov;
      int         exp_fe;
   } vec_t;

   vec_t tbl[14];

   uart_rx #(.OVERSAMPLE(16)) dut (
      .clk(clk), .rst(rst), .sampleTick(sampleTick), .rx(rx), .ack(ack),
      .data(data), .valid(valid), .frameErr(frameErr), .overrun(overrun),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // tick enable generation and frameErr/busy monitoring, away from posedge
   always @(negedge clk) begin
      tick_ph = (tick_ph + 1) % tick_div;
      sampleTick = (tick_ph == 0);
      if (frameErr) fe_cycles++;
      if (frameErr && !fe_last) fe_pulses++;
      fe_last = frameErr;
      if (busy) busy_seen = 1'b1;
   end

   function automatic vec_t mk(bit a, logic [7:0] b, logic s, int d, int v, int o, int f);
      vec_t r;
      r.is_ack = a; r.b = b; r.stop = s;
      r.exp_data = d; r.exp_valid = v; r.exp_ov = o; r.exp_fe = f;
      return r;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      applied++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Model: a frame is the 10-bit sequence start, d0..d7, stop as seen on the line
   task automatic model_frame(input logic [7:0] b, input logic stop, input bit ack_hit);
      logic [9:0] line;
      int val;
      line = {stop, b, 1'b0};
      val = 0;
      for (int i = 0; i < 8; i++) if (line[1 + i]) val += (1 << i);
      if (line[9]) begin
         m_ov = (m_valid != 0 && !ack_hit) ? 1 : 0;
         m_data = val;
         m_valid = 1;
      end else begin
         m_fe++;
      end
   endtask

   task automatic model_ack();
      if (m_valid != 0) begin
         m_valid = 0;
         m_ov = 0;
      end
   endtask

   task automatic check_all(input string tag);
      check($sformatf("%s.data", tag), int'(data), m_data);
      check($sformatf("%s.valid", tag), int'(valid), m_valid);
      check($sformatf("%s.overrun", tag), int'(overrun), m_ov);
      check($sformatf("%s.fe_pulses", tag), fe_pulses, m_fe);
      check($sformatf("%s.fe_cycles", tag), fe_cycles, m_fe);
   endtask

   // Drives one frame; rx is left at the stop level afterwards.
   // k counts negedges from the start-bit edge (k=0).
   task automatic send_frame(input logic [7:0] b, input logic stop, input int ack_at,
                             output int lat_valid, output int lat_busy);
      logic q[$];
      int bitclk;
      int k;
      q.push_back(1'b0);
      for (int i = 0; i < 8; i++) q.push_back(b[i]);
      q.push_back(stop);
      bitclk = 16 * int'(tick_div);
      lat_valid = -1;
      lat_busy = -1;
      for (int i = 0; i < 10; i++) begin
         for (int c = 0; c < bitclk; c++) begin
            @(negedge clk);
            k = i * bitclk + c;
            if (lat_valid < 0 && valid) lat_valid = k;
            if (lat_busy < 0 && busy) lat_busy = k;
            if (c == 0) rx = q[i];
            ack = (k == ack_at);
         end
      end
      ack = 1'b0;
   endtask

   task automatic run_send(input logic [7:0] b, input logic stop);
      int lv, lb;
      send_frame(b, stop, -1, lv, lb);
      rx = 1'b1;
      idle(24);
      model_frame(b, stop, 1'b0);
   endtask

   task automatic run_ack();
      @(negedge clk);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      model_ack();
   endtask

   initial begin
      int lv, lb;
      logic [7:0] rb;
      int op;

      tbl[0]  = mk(0, 8'hA5, 1, 'hA5, 1, 0, 0);
      tbl[1]  = mk(1, 8'h00, 1, 'hA5, 0, 0, 0);
      tbl[2]  = mk(0, 8'h3C, 0, 'hA5, 0, 0, 1);
      tbl[3]  = mk(0, 8'h11, 1, 'h11, 1, 0, 1);
      tbl[4]  = mk(0, 8'h22, 1, 'h22, 1, 1, 1);
      tbl[5]  = mk(1, 8'h00, 1, 'h22, 0, 0, 1);
      tbl[6]  = mk(1, 8'h00, 1, 'h22, 0, 0, 1);
      tbl[7]  = mk(0, 8'h00, 1, 'h00, 1, 0, 1);
      tbl[8]  = mk(0, 8'hFF, 0, 'h00, 1, 0, 2);
      tbl[9]  = mk(1, 8'h00, 1, 'h00, 0, 0, 2);
      tbl[10] = mk(0, 8'h80, 1, 'h80, 1, 0, 2);
      tbl[11] = mk(0, 8'h01, 1, 'h01, 1, 1, 2);
      tbl[12] = mk(0, 8'h7E, 0, 'h01, 1, 1, 3);
      tbl[13] = mk(1, 8'h00, 1, 'h01, 0, 0, 3);

      // reset state
      rst = 1'b1;
      idle(4);
      check("rst.data", int'(data), 0);
      check("rst.valid", int'(valid), 0);
      check("rst.overrun", int'(overrun), 0);
      check("rst.frameErr", int'(frameErr), 0);
      check("rst.busy", int'(busy), 0);
      rst = 1'b0;
      idle(8);

      // good byte with latency: busy after 3 edges, valid after 157
      send_frame(8'hA5, 1'b1, -1, lv, lb);
      rx = 1'b1;
      idle(24);
      model_frame(8'hA5, 1'b1, 1'b0);
      check("good.lat_valid", lv, 157);
      check("good.lat_busy", lb, 3);
      check_all("good");
      run_ack();
      check_all("good_ack");

      // false start: 4 clk low pulse
      idle(4);
      busy_seen = 1'b0;
      @(negedge clk);
      rx = 1'b0;
      idle(4);
      rx = 1'b1;
      idle(30);
      check("false.busy_seen", int'(busy_seen), 1);
      check("false.busy", int'(busy), 0);
      check_all("false");
      run_send(8'h3C, 1'b1);
      check_all("after_false");
      run_ack();

      // framing error followed by a held-low line
      run_send(8'h5A, 1'b1);
      run_ack();
      send_frame(8'h3C, 1'b0, -1, lv, lb);
      model_frame(8'h3C, 1'b0, 1'b0);
      idle(2);
      busy_seen = 1'b0;
      idle(48);
      check("break.busy_seen_low", int'(busy_seen), 0);
      rx = 1'b1;
      idle(24);
      check("break.busy_seen_high", int'(busy_seen), 0);
      check_all("ferr");
      run_send(8'hC3, 1'b1);
      check_all("after_ferr");
      run_ack();

      // table-driven vectors
      fe_cycles = 0;
      fe_pulses = 0;
      m_fe = 0;
      for (int i = 0; i < 14; i++) begin
         if (tbl[i].is_ack) run_ack();
         else run_send(tbl[i].b, tbl[i].stop);
         check($sformatf("tbl%0d.data", i), int'(data), tbl[i].exp_data);
         check($sformatf("tbl%0d.valid", i), int'(valid), tbl[i].exp_valid);
         check($sformatf("tbl%0d.overrun", i), int'(overrun), tbl[i].exp_ov);
         check($sformatf("tbl%0d.fe", i), fe_pulses, tbl[i].exp_fe);
         check($sformatf("tbl%0d.fe_width", i), fe_cycles, tbl[i].exp_fe);
      end

      // ack collides with the completion of the second back-to-back byte
      send_frame(8'h11, 1'b1, -1, lv, lb);
      model_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, 156, lv, lb);
      model_frame(8'h22, 1'b1, 1'b1);
      rx = 1'b1;
      idle(24);
      check_all("collide");
      run_ack();
      check_all("collide_ack");

      // reset during DATA bit 4 of 0xFF, with a pending byte present
      run_send(8'h77, 1'b1);
      run_send(8'h66, 1'b1);
      @(negedge clk);
      rx = 1'b0;
      idle(16);
      rx = 1'b1;
      idle(74);
      check("midrst.busy_before", int'(busy), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_data = 0;
      m_valid = 0;
      m_ov = 0;
      check("midrst.busy", int'(busy), 0);
      check("midrst.frameErr", int'(frameErr), 0);
      check_all("midrst");
      idle(120);
      check_all("midrst_quiet");
      run_send(8'h5A, 1'b1);
      check_all("after_rst");
      run_ack();

      // 1-in-4 tick enable, 64 clk per bit
      tick_div = 4;
      idle(8);
      run_send(8'h96, 1'b1);
      check_all("tick4");
      run_ack();

      // randomized operations against the model
      for (int n = 0; n < 40; n++) begin
         tick_div = ($urandom_range(0, 3) == 0) ? 2 : 1;
         idle(4);
         op = $urandom_range(0, 9);
         rb = 8'($urandom);
         if (op < 2) run_ack();
         else if (op == 2) run_send(rb, 1'b0);
         else run_send(rb, 1'b1);
         check_all($sformatf("rnd%0d", n));
      end

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
